// File: rtl/registro_operando_pipe.sv
// Operand register for the sum-and-shift multiplier: valid/ready intake with one-bit
// sign/zero extension, a DEPTH-stage delay pipeline and a right-shifting output register.
module registro_operando_pipe #(
  parameter int tamano = 8,
  parameter int DEPTH  = 2
) (
  input  logic                             CLOCK,
  input  logic                             RESET,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [tamano-1:0]                In_multi,
  input  logic                             signed_mode,
  input  logic                             shift_en,
  input  logic                             consume,
  output logic [tamano:0]                  Out_multi,
  output logic                             out_valid,
  output logic                             lsb,
  output logic [$clog2(tamano+1)-1:0]      shift_cnt,
  output logic                             done
);

  localparam int CW = $clog2(tamano + 1);

  typedef enum logic {EMPTY, HELD} out_state_t;

  out_state_t      state;
  logic            out_mode;
  logic [DEPTH-1:0] stg_valid;
  logic [DEPTH-1:0] stg_mode;
  logic [tamano:0]  stg_data [DEPTH];

  // can_load[k] means stage k (or the output register when k == DEPTH) takes new
  // contents on the next edge; the chain ripples a stall back from the output.
  logic [DEPTH:0]  can_load;
  logic [tamano:0] ext_in;

  always_comb begin
    // NOTE: assign every always_comb output up front so no path leaves it unassigned (latch).
    can_load        = '0;
    can_load[DEPTH] = (state == EMPTY) || consume;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      can_load[k] = !stg_valid[k] || can_load[k+1];
    end
  end

  assign ext_in   = {signed_mode & In_multi[tamano-1], In_multi};
  assign in_ready = can_load[0];
  assign lsb      = Out_multi[0];

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      stg_valid <= '0;
      stg_mode  <= '0;
      for (int k = 0; k < DEPTH; k++) stg_data[k] <= '0;
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      Out_multi <= '0;
      shift_cnt <= '0;
      done      <= 1'b0;
    end else begin
      if (can_load[0]) begin
        stg_valid[0] <= in_valid;
        stg_mode[0]  <= signed_mode;
        stg_data[0]  <= ext_in;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (can_load[k]) begin
          stg_valid[k] <= stg_valid[k-1];
          stg_mode[k]  <= stg_mode[k-1];
          stg_data[k]  <= stg_data[k-1];
        end
      end

      // Release/reload takes priority over shifting, so consume masks shift_en.
      if (can_load[DEPTH]) begin
        shift_cnt <= '0;
        done      <= 1'b0;
        if (stg_valid[DEPTH-1]) begin
          state     <= HELD;
          out_valid <= 1'b1;
          out_mode  <= stg_mode[DEPTH-1];
          Out_multi <= stg_data[DEPTH-1];
        end else begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      end else if (shift_en && !done) begin
        Out_multi <= {out_mode & Out_multi[tamano], Out_multi[tamano:1]};
        shift_cnt <= shift_cnt + 1'b1;
        done      <= (shift_cnt == CW'(tamano - 1));
      end
    end
  end

endmodule

// File: tb/tb_registro_operando_pipe.sv
// Self-checking bench for registro_operando_pipe: scoreboard of extended operands pushed at
// input transfer and compared when the operand is released or first appears.
module tb_registro_operando_pipe;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int CW = $clog2(W + 1);

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  In_multi = '0;
  logic          signed_mode = 1'b0;
  logic          shift_en = 1'b0;
  logic          consume = 1'b0;
  logic [W:0]    Out_multi;
  logic          out_valid;
  logic          lsb;
  logic [CW-1:0] shift_cnt;
  logic          done;

  int         checks = 0;
  int         errors = 0;
  logic [W:0] sb [$];

  registro_operando_pipe #(.tamano(W), .DEPTH(D)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .In_multi(In_multi), .signed_mode(signed_mode), .shift_en(shift_en),
    .consume(consume), .Out_multi(Out_multi), .out_valid(out_valid), .lsb(lsb),
    .shift_cnt(shift_cnt), .done(done)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] ext_model(input logic [W-1:0] d, input logic sm);
    return {sm ? d[W-1] : 1'b0, d};
  endfunction

  // One clock: record transfers/releases seen before the edge, then step past the edge.
  task automatic tick();
    logic [W:0] exp;
    #1;
    if (!RESET && in_valid && in_ready) sb.push_back(ext_model(In_multi, signed_mode));
    if (!RESET && out_valid && consume) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow released %h with nothing expected", Out_multi);
      end else begin
        exp = sb.pop_front();
        if (shift_cnt == 0) begin
          checks++;
          if (Out_multi !== exp) begin
            errors++;
            $display("FAIL release_order got %h required %h", Out_multi, exp);
          end
        end
      end
    end
    @(posedge CLOCK);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic sm);
    int  n;
    logic ok;
    n = 0;
    in_valid = 1'b1; In_multi = d; signed_mode = sm;
    do begin
      #1;
      ok = in_ready;
      tick();
      n++;
    end while (!ok && n < 20);
    in_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_timeout data %h in_ready=%b required 1", d, in_ready); end
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid timeout got %b required 1", name, out_valid); end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({Out_multi, out_valid, shift_cnt, done} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d Out=%h v=%b cnt=%0d done=%b required all 0",
                 i, Out_multi, out_valid, shift_cnt, done);
      end
    end
    RESET = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
  endtask

  task automatic test_latency();
    in_valid = 1'b1; In_multi = 8'hA5; signed_mode = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early after %0d edges out_valid=%b required 0", i, out_valid); end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || Out_multi !== sb[0] || Out_multi !== 9'h1A5) begin
      errors++;
      $display("FAIL latency_arrival v=%b Out=%h required v=1 Out=%h", out_valid, Out_multi, 9'h1A5);
    end
    checks++;
    if (shift_cnt !== '0 || lsb !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL latency_status cnt=%0d lsb=%b done=%b required 0/1/0", shift_cnt, lsb, done);
    end
    consume = 1'b1; tick(); consume = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL consume_empty out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_unsigned_shift();
    send(8'h80, 1'b0);
    wait_out("unsigned");
    checks++;
    if (Out_multi !== sb[0]) begin errors++; $display("FAIL unsigned_ext got %h required %h", Out_multi, sb[0]); end
    shift_en = 1'b1;
    repeat (3) tick();
    shift_en = 1'b0;
    checks++;
    if (Out_multi !== 9'h010 || lsb !== 1'b0 || shift_cnt !== CW'(3)) begin
      errors++;
      $display("FAIL logical_shift Out=%h lsb=%b cnt=%0d required 010/0/3", Out_multi, lsb, shift_cnt);
    end
    consume = 1'b1; tick(); consume = 1'b0;
  endtask

  task automatic test_arith_done();
    send(8'hF0, 1'b1);
    wait_out("arith");
    checks++;
    if (Out_multi !== sb[0] || Out_multi !== 9'h1F0) begin errors++; $display("FAIL signed_ext got %h required 1f0", Out_multi); end
    shift_en = 1'b1;
    repeat (7) tick();
    checks++;
    if (done !== 1'b0 || shift_cnt !== CW'(7)) begin errors++; $display("FAIL done_early done=%b cnt=%0d required 0/7", done, shift_cnt); end
    tick();
    checks++;
    if (Out_multi !== 9'h1FF || done !== 1'b1 || shift_cnt !== CW'(8)) begin
      errors++;
      $display("FAIL arith_done Out=%h done=%b cnt=%0d required 1ff/1/8", Out_multi, done, shift_cnt);
    end
    tick();
    shift_en = 1'b0;
    checks++;
    if (Out_multi !== 9'h1FF || done !== 1'b1 || shift_cnt !== CW'(8)) begin
      errors++;
      $display("FAIL shift_after_done Out=%h done=%b cnt=%0d required 1ff/1/8", Out_multi, done, shift_cnt);
    end
    consume = 1'b1; tick(); consume = 1'b0;
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL done_clear done=%b v=%b required 0/0", done, out_valid); end
  endtask

  task automatic test_back_to_back();
    int   idx, popped, n;
    logic acc, pv;
    idx = 0; popped = 0; n = 0;
    consume = 1'b0; signed_mode = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; In_multi = W'(idx + 1);
      #1; acc = in_ready;
      tick();
      if (acc) idx++;
    end
    #1;
    checks++;
    if (idx != D + 1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure accepted=%0d in_ready=%b required %0d/0", idx, in_ready, D + 1);
    end
    consume = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL full_throughput in_ready=%b required 1", in_ready); end
    while (popped < 4 && n < 20) begin
      if (idx < 4) begin in_valid = 1'b1; In_multi = W'(idx + 1); end
      else in_valid = 1'b0;
      #1; acc = in_ready; pv = out_valid;
      tick();
      if (acc && idx < 4) idx++;
      if (pv) popped++;
      n++;
    end
    in_valid = 1'b0; consume = 1'b0;
    checks++;
    if (popped != 4 || sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain popped=%0d left=%0d v=%b required 4/0/0", popped, sb.size(), out_valid);
    end
  endtask

  task automatic test_priority();
    send(8'hF0, 1'b0);
    send(8'h33, 1'b0);
    wait_out("priority");
    checks++;
    if (Out_multi !== 9'h0F0) begin errors++; $display("FAIL priority_held got %h required 0f0", Out_multi); end
    consume = 1'b1; shift_en = 1'b1;
    tick();
    consume = 1'b0; shift_en = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || Out_multi !== sb[0] || shift_cnt !== '0) begin
      errors++;
      $display("FAIL priority_reload v=%b Out=%h cnt=%0d required 1/%h/0", out_valid, Out_multi, shift_cnt, sb[0]);
    end
    consume = 1'b1; tick(); consume = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    send(8'h5A, 1'b0);
    wait_out("reset_mid");
    shift_en = 1'b1; in_valid = 1'b1; In_multi = 8'h11;
    tick();
    In_multi = 8'h22;
    tick();
    shift_en = 1'b0; in_valid = 1'b0;
    checks++;
    if (shift_cnt !== CW'(2) || Out_multi !== 9'h016) begin
      errors++;
      $display("FAIL pre_reset cnt=%0d Out=%h required 2/016", shift_cnt, Out_multi);
    end
    RESET = 1'b1; tick(); RESET = 1'b0;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || shift_cnt !== '0 || Out_multi !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset v=%b cnt=%0d Out=%h done=%b required all 0", out_valid, shift_cnt, Out_multi, done);
    end
    seen = 1'b0;
    repeat (8) begin tick(); seen |= out_valid; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL flushed_operand out_valid seen=%b required 0", seen); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_unsigned_shift();
    test_arith_done();
    test_back_to_back();
    test_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
